mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL provide parameter STARVE_LIMIT, default 4, giving the consecutive D grants after which a waiting I request wins; legal values 1..15.
REQ-002 The block SHALL provide parameter TIMEOUT, default 15, giving the ACCESS cycles without m_ready after which the access aborts; legal values 1..255.
REQ-003 The block SHALL provide the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i_req  in  1  instruction-fetch request; held until i_ack.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetched word.
- i_ack  out  1  fetch-complete pulse.
- d_req  in  1  data request; held until d_ack.
- d_wen  in  1  1 = write, 0 = read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read word.
- d_ack  out  1  data-complete pulse.
- m_req  out  1  shared-memory request.
- m_wen  out  1  shared-memory write enable.
- m_addr  out  32  shared-memory address.
- m_wdata  out  32  shared-memory write data.
- m_rdata  in  32  shared-memory read data.
- m_ready  in  1  shared-memory completion strobe.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and RESP. Every m_*, ack, rdata and err output SHALL be registered.
REQ-005 In IDLE with neither req high, the FSM SHALL stay in IDLE and hold m_req at 0.
REQ-006 In IDLE with any req high, the block SHALL pick a winner, latch the winner's addr/wen/wdata onto m_*, set m_req=1 and enter ACCESS on the next edge.
- Latency: 1 cycle from req sampled to m_req high.
REQ-007 Winner selection SHALL be:
- D beats I by default.
- I wins when both are requesting and starve_cnt == STARVE_LIMIT.
- I requests never carry a write: m_wen=0 for I.
REQ-008 The 4-bit starve_cnt SHALL update at each grant:
- +1, saturating at STARVE_LIMIT, when D is granted while i_req=1.
- Cleared to 0 when I is granted or when i_req=0 at the grant.
REQ-009 m_addr SHALL equal the requester address with bits [1:0] forced to 00; data SHALL pass through without byte reordering.
REQ-010 In ACCESS, m_req, m_wen, m_addr and m_wdata SHALL stay stable until m_ready=1 is sampled.
REQ-011 When m_ready=1 is sampled in ACCESS, the block SHALL, on the same edge:
- For a read, capture m_rdata into the owner's rdata register.
- Clear m_req and m_wen.
- Enter RESP.
REQ-012 In RESP, the owner's ack SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.
- Latency from m_ready sampled to ack high: 1 cycle.
- The non-owner's ack SHALL stay 0.
REQ-013 A requester SHALL drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.
REQ-014 Write completion SHALL pulse d_ack and leave d_rdata unchanged.
- i_rdata and d_rdata SHALL otherwise hold their last captured value.
REQ-015 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with m_ready=0.
- When the counter reaches TIMEOUT, the block SHALL set err=1, clear m_req, leave rdata unchanged, and enter RESP so the owner still receives its ack.
REQ-016 m_ready seen outside ACCESS SHALL be ignored.
- Changes on req, addr or wdata during ACCESS or RESP SHALL be ignored.
REQ-017 Only one ack SHALL be high in any cycle, and no ack SHALL be high outside RESP.

Reset
REQ-018 While rst_n=0 at an edge, the block SHALL:
- Enter IDLE.
- Set m_req, m_wen, i_ack, d_ack, err and busy to 0.
- Set m_addr, m_wdata, i_rdata and d_rdata to 32'h0.
- Set starve_cnt and the wait counter to 0.
REQ-019 A reset asserted during ACCESS or RESP SHALL abort the transaction with no ack issued.
- m_req SHALL be 0 from the first post-reset-edge cycle onward.
- err is cleared only by reset.

Verification
REQ-020 Scenario, single fetch:
- Stimulus: i_req=1, i_addr=32'h0000_0106; m_ready=1 two cycles after m_req rises, m_rdata=32'hDEAD_BEEF.
- Required: m_addr=32'h0000_0104, m_wen=0; i_ack pulses once; i_rdata=32'hDEAD_BEEF; d_ack stays 0.
REQ-021 Scenario, simultaneous requests:
- Stimulus: i_req and d_req rise together; d_wen=1, d_addr=32'h40, d_wdata=32'h1234_5678.
- Required: D is granted first with m_wen=1, m_wdata=32'h1234_5678; d_ack pulses; d_rdata unchanged; I is granted next.
REQ-022 Scenario, starvation:
- Stimulus: i_req held high while d_req is continuously re-asserted; STARVE_LIMIT=4; m_ready returned immediately.
- Required: four D grants, then the fifth grant goes to I; starve_cnt reads 0 after the I grant.
REQ-023 Scenario, timeout:
- Stimulus: d_req read; m_ready never asserted; TIMEOUT=15.
- Required: m_req high for 15 cycles then low; err=1; d_ack pulses once; d_rdata unchanged; err stays 1 across later transactions.
REQ-024 Scenario, reset mid-ACCESS:
- Stimulus: rst_n=0 for 1 cycle while m_req=1.
- Required: the next cycle shows m_req=0, busy=0, err=0, no ack, and all data outputs 32'h0; a fresh i_req then completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter onto one shared memory port
// D has priority; a waiting fetch wins after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner_d;
  logic [3:0]  starve_cnt;
  logic [7:0]  wait_cnt;
  logic        req_any, grant_d, mem_done, mem_abort;
  logic [31:0] sel_addr;

  assign req_any   = i_req | d_req;
  assign grant_d   = d_req & ~(i_req & (starve_cnt == STARVE_MAX));
  assign sel_addr  = grant_d ? d_addr : i_addr;
  assign mem_done  = (state == ACCESS) & m_ready;
  assign mem_abort = (state == ACCESS) & ~m_ready & (wait_cnt == WAIT_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ACCESS;
      ACCESS:  if (mem_done || mem_abort) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_d    <= 1'b0;
      starve_cnt <= 4'd0;
      wait_cnt   <= 8'd0;
      m_req      <= 1'b0;
      m_wen      <= 1'b0;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      i_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            owner_d  <= grant_d;
            m_req    <= 1'b1;
            m_wen    <= grant_d & d_wen;
            m_addr   <= sel_addr & 32'hFFFF_FFFC;
            m_wdata  <= grant_d ? d_wdata : m_wdata;
            wait_cnt <= 8'd0;
            // Starvation only accrues while a fetch is actually waiting.
            if (grant_d && i_req)
              starve_cnt <= (starve_cnt >= STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
            else
              starve_cnt <= 4'd0;
          end
        end
        ACCESS: begin
          if (mem_done || mem_abort) begin
            m_req <= 1'b0;
            m_wen <= 1'b0;
            if (owner_d) d_ack <= 1'b1;
            else         i_ack <= 1'b1;
          end
          if (!m_ready) wait_cnt <= wait_cnt + 8'd1;
          if (mem_abort) err <= 1'b1;
          if (mem_done && !m_wen) begin
            if (owner_d) d_rdata <= m_rdata;
            else         i_rdata <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
